// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the fetch stage, the LSU, the memory-port arbiter and the memory.
// The master modport is the arbiter's view; slave is the view of the surrounding blocks.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            pc_v_x;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            stall_i;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_req;
    logic            mem_gnt;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  i_req, i_addr, pc_v_x,
        output i_rvalid, i_rdata, stall_i,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output i_req, i_addr, pc_v_x,
        input  i_rvalid, i_rdata, stall_i,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and load/store (D),
// D priority with an I anti-starvation window. Define MEM_ARB_PERF_EN for perf counters.
module mem_port_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int D_WIN = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_i_stall,
    output logic [31:0]        perf_d_wait
`endif
);
    localparam int CW = (D_WIN < 1) ? 1 : $clog2(D_WIN + 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   win_cnt_q, win_cnt_d;
    logic            kill_q, kill_d;

    logic            d_win, i_win, d_grant, i_grant;
    logic            we_sel;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [DW/8-1:0] be_sel;

    // Winner is gated by reset_n so nothing is requested while reset is held.
    always_comb begin
        d_win = 1'b0;
        i_win = 1'b0;
        if (reset_n && state_q == IDLE) begin
            d_win = bus.d_req && !(bus.i_req && win_cnt_q == CW'(D_WIN));
            i_win = bus.i_req && !d_win;
        end
    end

    assign d_grant = d_win && bus.mem_gnt;
    assign i_grant = i_win && bus.mem_gnt;

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        be_sel    = '0;
        if (d_win) begin
            we_sel    = bus.d_we;
            addr_sel  = bus.d_addr;
            wdata_sel = bus.d_wdata;
            be_sel    = bus.d_be;
        end else if (i_win) begin
            addr_sel  = bus.i_addr;
            be_sel    = '1;
        end
    end

    assign bus.mem_req   = d_win || i_win;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.mem_be    = be_sel;

    assign bus.d_gnt     = d_grant;
    assign bus.d_rvalid  = (state_q == WAIT_D) && bus.mem_rvalid;
    assign bus.d_rdata   = reset_n ? bus.mem_rdata : '0;
    assign bus.i_rvalid  = (state_q == WAIT_I) && bus.mem_rvalid && !kill_q && !bus.pc_v_x;
    assign bus.i_rdata   = reset_n ? bus.mem_rdata : '0;
    assign bus.stall_i   = !reset_n || (bus.i_req && !i_grant);

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (d_grant)      state_d = WAIT_D;
                else if (i_grant) state_d = WAIT_I;
            end
            WAIT_I: begin
                // A response coincident with a redirect is dropped via the output gate, so kill stays clear.
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end else if (bus.pc_v_x) begin
                    kill_d  = 1'b1;
                end
            end
            WAIT_D: begin
                if (bus.mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.i_req || i_grant)
            win_cnt_d = '0;
        else if (d_grant && win_cnt_q != CW'(D_WIN))
            win_cnt_d = win_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            kill_q    <= kill_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_stall_q, perf_d_wait_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_stall_q <= '0;
            perf_d_wait_q  <= '0;
        end else begin
            if (bus.stall_i && bus.i_req) perf_i_stall_q <= perf_i_stall_q + 32'd1;
            if (bus.d_req && !d_grant)    perf_d_wait_q  <= perf_d_wait_q + 32'd1;
        end
    end

    assign perf_i_stall = perf_i_stall_q;
    assign perf_d_wait  = perf_d_wait_q;
`endif
endmodule
